mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array.sv | 38 +++
 rtl/mem_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory responder and its RAM.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 9;
  localparam int DEPTH_DEF  = 512;
  localparam int CNT_W      = 4;

  localparam logic KIND_READ  = 1'b0;
  localparam logic KIND_WRITE = 1'b1;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port DEPTH x 32 synchronous RAM with write enable and registered read.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Storage write; contents are intentionally untouched by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port; output register clears on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: strobe-edge memory responder with fixed-latency mem_ready handshake.
// Build macro MEM_ADDR_CHECK_EN enables out-of-range address faulting (addr_fault).
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Read,
  input  logic        write_mem,
  input  logic [31:0] MAR_q,
  input  logic [31:0] MDR_q,
  output logic [31:0] Mdatain,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        overrun,
  output logic        addr_fault
);

  state_t             state_r, next_state_s;
  logic               read_d_r, write_d_r, rd_armed_r, wr_armed_r;
  logic               rd_req_s, wr_req_s, capture_s, commit_s, drop_s, upper_nz_s;
  logic               kind_r, req_fault_r, rd_zero_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [31:0]        data_r, rdata_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               ready_r, busy_r, overrun_r;
  logic               we_s, re_s;

  // The armed flags stop a strobe that is still high out of reset from counting as a new edge.
  assign rd_req_s = Read & ~read_d_r & rd_armed_r;
  assign wr_req_s = write_mem & ~write_d_r & wr_armed_r;

`ifdef MEM_ADDR_CHECK_EN
  logic fault_r;
  assign upper_nz_s = |MAR_q[31:ADDR_W];

  // Sticky out-of-range flag, raised when such a request is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_r <= 1'b0;
    end else if (capture_s && upper_nz_s) begin
      fault_r <= 1'b1;
    end
  end

  assign addr_fault = fault_r;
`else
  logic unused_upper_s;
  assign unused_upper_s = ^MAR_q[31:ADDR_W];
  assign upper_nz_s     = 1'b0;
  assign addr_fault     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    commit_s     = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        drop_s = rd_req_s & wr_req_s;
        if (rd_req_s || wr_req_s) begin
          capture_s    = 1'b1;
          next_state_s = ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        drop_s = rd_req_s | wr_req_s;
        if (cnt_r == {CNT_W{1'b0}}) begin
          commit_s     = 1'b1;
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        drop_s       = rd_req_s | wr_req_s;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Edge detection, request capture, latency count and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_d_r    <= 1'b0;
      write_d_r   <= 1'b0;
      rd_armed_r  <= ~Read;
      wr_armed_r  <= ~write_mem;
      kind_r      <= KIND_READ;
      req_fault_r <= 1'b0;
      rd_zero_r   <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= 32'h0000_0000;
      cnt_r       <= {CNT_W{1'b0}};
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      read_d_r   <= Read;
      write_d_r  <= write_mem;
      rd_armed_r <= rd_armed_r | ~Read;
      wr_armed_r <= wr_armed_r | ~write_mem;
      if (capture_s) begin
        kind_r      <= wr_req_s ? KIND_WRITE : KIND_READ;
        req_fault_r <= upper_nz_s;
        addr_r      <= MAR_q[ADDR_W-1:0];
        data_r      <= MDR_q;
        cnt_r       <= CNT_W'(LATENCY - 1);
      end else if (state_r == ST_BUSY && cnt_r != {CNT_W{1'b0}}) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (re_s) begin
        rd_zero_r <= req_fault_r;
      end
      ready_r   <= commit_s;
      busy_r    <= (next_state_s != ST_IDLE);
      overrun_r <= overrun_r | drop_s;
    end
  end

  assign we_s = commit_s & (kind_r == KIND_WRITE) & ~req_fault_r;
  assign re_s = commit_s & (kind_r == KIND_READ);

  mem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .re    (re_s),
    .addr  (addr_r),
    .wdata (data_r),
    .rdata (rdata_s)
  );

  assign Mdatain   = rd_zero_r ? 32'h0000_0000 : rdata_s;
  assign mem_ready = ready_r;
  assign mem_busy  = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus randomized bench for mem_responder against a word-level memory model.
module tb_mem_responder;

  localparam int LAT    = 2;
  localparam int ADDR_W = 9;
`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Read = 1'b0;
  logic        write_mem = 1'b0;
  logic [31:0] MAR_q = 32'h0;
  logic [31:0] MDR_q = 32'h0;
  logic [31:0] Mdatain;
  logic        mem_ready, mem_busy, overrun, addr_fault;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [int];
  logic [31:0] model_mdat = 32'h0;
  bit          model_overrun = 1'b0;
  bit          model_fault = 1'b0;

  mem_responder #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .Read       (Read),
    .write_mem  (write_mem),
    .MAR_q      (MAR_q),
    .MDR_q      (MDR_q),
    .Mdatain    (Mdatain),
    .mem_ready  (mem_ready),
    .mem_busy   (mem_busy),
    .overrun    (overrun),
    .addr_fault (addr_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Read = 1'b0;
    write_mem = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mdatain", Mdatain, 32'h0);
    chk("rst_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_busy", {31'h0, mem_busy}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_fault", {31'h0, addr_fault}, 32'h0);
    reset = 1'b0;
    model_overrun = 1'b0;
    model_fault = 1'b0;
    model_mdat = 32'h0;
    @(posedge clk);
    #1;
  endtask

  // One request with the strobe(s) held for 'hold' cycles; model updated from the access rules.
  task automatic access(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                        input logic [31:0] data, input int hold);
    int          ready_k;
    int          n_ready;
    int          idx;
    bit          fault;
    logic [31:0] mdat_at;
    fault = CHK && (addr[31:ADDR_W] != 0);
    idx = int'(addr[ADDR_W-1:0]);
    if (fault) model_fault = 1'b1;
    if (do_rd && do_wr) model_overrun = 1'b1;
    if (do_wr) begin
      if (!fault) model_mem[idx] = data;
    end else if (do_rd) begin
      model_mdat = fault ? 32'h0 : model_mem[idx];
    end
    Read = do_rd;
    write_mem = do_wr;
    MAR_q = addr;
    MDR_q = data;
    ready_k = -1;
    n_ready = 0;
    mdat_at = 32'hx;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == hold - 1) begin
        Read = 1'b0;
        write_mem = 1'b0;
      end
      if (mem_ready) begin
        n_ready++;
        if (ready_k < 0) begin
          ready_k = k;
          mdat_at = Mdatain;
        end
      end
      if (k == 0) chk("busy_start", {31'h0, mem_busy}, 32'h1);
      if (k == LAT) chk("busy_done", {31'h0, mem_busy}, 32'h1);
      if (k == LAT + 1) chk("busy_end", {31'h0, mem_busy}, 32'h0);
    end
    chk("ready_cycle", ready_k, LAT);
    chk("ready_count", n_ready, 32'd1);
    chk("mdat_at_ready", mdat_at, model_mdat);
    chk("mdat_held", Mdatain, model_mdat);
    chk("overrun", {31'h0, overrun}, {31'h0, model_overrun});
    chk("addr_fault", {31'h0, addr_fault}, {31'h0, model_fault});
  endtask

  initial begin
    int n;
    logic [31:0] a;

    do_reset();

    // Write then read back.
    access(1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 1);
    access(1'b1, 1'b0, 32'h5, 32'h0, 1);

    // Read strobe held for six cycles produces a single request.
    model_mem[16] = model_mem.exists(16) ? model_mem[16] : 32'h0;
    access(1'b0, 1'b1, 32'h10, 32'h0, 1);
    access(1'b1, 1'b0, 32'h10, 32'h0, 6);

    // Write edge during the BUSY phase of a read is dropped.
    Read = 1'b1;
    MAR_q = 32'h5;
    @(posedge clk); #1;
    Read = 1'b0;
    @(posedge clk); #1;
    write_mem = 1'b1;
    MDR_q = 32'h1111_1111;
    @(posedge clk); #1;
    write_mem = 1'b0;
    chk("ovr_ready", {31'h0, mem_ready}, 32'h1);
    chk("ovr_data", Mdatain, 32'hDEADBEEF);
    chk("ovr_flag", {31'h0, overrun}, 32'h1);
    model_overrun = 1'b1;
    model_mdat = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h5, 32'h0, 1);

    // Simultaneous read and write: write wins, overrun set.
    do_reset();
    access(1'b1, 1'b1, 32'h7, 32'h12345678, 1);
    access(1'b1, 1'b0, 32'h7, 32'h0, 1);

    // Reset one cycle after a write edge aborts the write.
    access(1'b0, 1'b1, 32'h8, 32'hAAAA0000, 1);
    write_mem = 1'b1;
    MAR_q = 32'h8;
    MDR_q = 32'h5555_5555;
    @(posedge clk); #1;
    write_mem = 1'b0;
    reset = 1'b1;
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_ready) n++;
    end
    chk("abort_mdat", Mdatain, 32'h0);
    chk("abort_busy", {31'h0, mem_busy}, 32'h0);
    chk("abort_ovr", {31'h0, overrun}, 32'h0);
    reset = 1'b0;
    model_overrun = 1'b0;
    model_fault = 1'b0;
    model_mdat = 32'h0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_ready) n++;
    end
    chk("abort_no_ready", n, 32'd0);
    access(1'b1, 1'b0, 32'h8, 32'h0, 1);

    // Strobe high through reset release is not a request until it toggles.
    Read = 1'b1;
    MAR_q = 32'h5;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_overrun = 1'b0;
    model_fault = 1'b0;
    model_mdat = 32'h0;
    n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready || mem_busy) n++;
    end
    chk("held_strobe_idle", n, 32'd0);
    Read = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h5, 32'h0, 1);

    // Upper address bits: alias to word 0, or fault when checking is built in.
    access(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1);
    access(1'b1, 1'b0, 32'h200, 32'h0, 1);
    access(1'b0, 1'b1, 32'h0000_0A03, 32'h0BAD_0BAD, 1);
    access(1'b1, 1'b0, 32'h3, 32'h0, 1);

    // Randomized traffic over a small address window.
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 1'b1, 32'(i), $urandom, 1);
    end
    for (int i = 0; i < 30; i++) begin
      a = 32'($urandom_range(0, 15));
      access(1'b1, ($urandom_range(0, 1) == 1), a, $urandom, $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
